// File: rtl/cpu_test_pkg.sv
// ============================================================================
// Module : cpu_test_pkg
// Brief  : Shared types and constants for the CPU test sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_test_pkg;

  // Sequencer phases
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Trace record kinds
  localparam logic KIND_FETCH = 1'b0;
  localparam logic KIND_STORE = 1'b1;

  // Width of the kind field at the top of every trace record
  localparam int KIND_W = 1;

  // Record width: {kind, tid, addr, data[, timestamp]}
  function automatic int rec_width(input int tid_w, input int addr_w,
                                   input int data_w, input int ts_w);
    return KIND_W + tid_w + addr_w + data_w + ts_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_trace_fifo.sv
// ============================================================================
// Module : cpu_trace_fifo
// Brief  : First-word-fall-through FIFO; reports pushes dropped while full.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_trace_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  // Pointers carry one wrap bit so full and empty are distinguishable
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  assign valid_o    = !empty;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance read/write pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/cpu_test_sequencer.sv
// ============================================================================
// Module : cpu_test_sequencer
// Brief  : Runs NUM_TESTS CPU image banks back to back, times each run to HLT
//          or timeout and streams a fetch / watched-store trace.
// Config : CPU_TEST_TIMESTAMP_EN adds trace_time (cycle count at capture).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_test_sequencer
  import cpu_test_pkg::*;
#(
  parameter int                ADDR_W      = 13,
  parameter int                DATA_W      = 8,
  parameter int                NUM_TESTS   = 3,
  parameter int                TID_W       = 2,
  parameter int                RST_CYCLES  = 2,
  parameter int                TIMEOUT_W   = 16,
  parameter int                TRACE_DEPTH = 16,
  parameter logic [ADDR_W-1:0] WATCH_ADDR  = 13'h0002
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_TESTS*TIMEOUT_W-1:0] timeout_vec,
  output logic                           cpu_rst_n,
  output logic [TID_W-1:0]               bank_sel,
  input  logic                           cpu_halt,
  input  logic                           cpu_fetch,
  input  logic                           bus_rd,
  input  logic                           bus_wr,
  input  logic [ADDR_W-1:0]              bus_addr,
  input  logic [DATA_W-1:0]              bus_data,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic                           trace_kind,
  output logic [TID_W-1:0]               trace_tid,
  output logic [ADDR_W-1:0]              trace_addr,
  output logic [DATA_W-1:0]              trace_data,
  output logic                           test_done,
  output logic                           test_halted,
  output logic [TIMEOUT_W-1:0]           test_cycles,
  output logic                           busy,
  output logic                           all_done,
  output logic                           trace_ovf
`ifdef CPU_TEST_TIMESTAMP_EN
  ,
  output logic [TIMEOUT_W-1:0]           trace_time
`endif
);

`ifdef CPU_TEST_TIMESTAMP_EN
  localparam int TS_W = TIMEOUT_W;
`else
  localparam int TS_W = 0;
`endif
  localparam int REC_W = rec_width(TID_W, ADDR_W, DATA_W, TS_W);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);

  state_t               state_q, state_d;
  logic [TID_W-1:0]     tid_q;
  logic [RC_W-1:0]      rst_cnt_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cycles_q;
  logic                 halted_q;
  logic                 halt_prev_q;
  logic                 wr_prev_q;
  logic                 fetch_prev_q;
  logic [ADDR_W-1:0]    last_fetch_q;
  logic                 ovf_q;

  logic [TIMEOUT_W-1:0] limit;
  logic                 in_run;
  logic                 rst_done;
  logic                 halt_rise;
  logic                 limit_hit;
  logic                 is_last;
  logic                 fetch_act;
  logic                 fetch_cap;
  logic                 store_cap;
  logic                 push;
  logic [REC_W-1:0]     push_rec;
  logic [REC_W-1:0]     pop_rec;
  logic                 fifo_drop;

  // Per-test cycle limit of the current test; limit 0 wraps to 2**TIMEOUT_W
  always_comb begin
    limit = timeout_vec[TIMEOUT_W-1:0];
    for (int i = 0; i < NUM_TESTS; i++) begin
      if (tid_q == TID_W'(i)) limit = timeout_vec[i*TIMEOUT_W +: TIMEOUT_W];
    end
  end

  assign in_run    = (state_q == ST_RUN);
  assign rst_done  = (rst_cnt_q == RC_W'(RST_CYCLES - 1));
  assign halt_rise = cpu_halt && !halt_prev_q;
  assign limit_hit = (cnt_q == limit - TIMEOUT_W'(1));
  assign is_last   = (tid_q == TID_W'(NUM_TESTS - 1));

  // Capture qualifiers; a simultaneous store wins over the fetch
  assign fetch_act = cpu_fetch && bus_rd;
  assign fetch_cap = in_run && fetch_act && (!fetch_prev_q || (bus_addr != last_fetch_q));
  assign store_cap = in_run && bus_wr && !wr_prev_q && (bus_addr == WATCH_ADDR);
  assign push      = fetch_cap || store_cap;

`ifdef CPU_TEST_TIMESTAMP_EN
  assign push_rec = {(store_cap ? KIND_STORE : KIND_FETCH), tid_q, bus_addr, bus_data, cnt_q};
  assign {trace_kind, trace_tid, trace_addr, trace_data, trace_time} = pop_rec;
`else
  assign push_rec = {(store_cap ? KIND_STORE : KIND_FETCH), tid_q, bus_addr, bus_data};
  assign {trace_kind, trace_tid, trace_addr, trace_data} = pop_rec;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and phase-decoded outputs
  always_comb begin
    state_d   = state_q;
    cpu_rst_n = 1'b0;
    test_done = 1'b0;
    busy      = 1'b0;
    all_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RESET;
      end
      ST_RESET: begin
        busy = 1'b1;
        if (rst_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        cpu_rst_n = 1'b1;
        if (halt_rise || limit_hit) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        busy      = 1'b1;
        test_done = 1'b1;
        state_d   = is_last ? ST_DONE : ST_RESET;
      end
      ST_DONE: begin
        all_done = 1'b1;
        if (start) state_d = ST_RESET;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Test index, reset-phase length and run-cycle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      tid_q     <= '0;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) tid_q <= '0;
      else if ((state_q == ST_REPORT) && !is_last)                 tid_q <= tid_q + TID_W'(1);
      rst_cnt_q <= ((state_q == ST_RESET) && !rst_done) ? rst_cnt_q + RC_W'(1) : '0;
      cnt_q     <= in_run ? cnt_q + TIMEOUT_W'(1) : '0;
    end
  end

  // Latch the test result as the run ends; held through REPORT
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      cycles_q <= '0;
    end else if (in_run && (halt_rise || limit_hit)) begin
      halted_q <= halt_rise;
      cycles_q <= (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);
    end
  end

  // Edge-detect history, last fetch address and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_prev_q  <= 1'b0;
      wr_prev_q    <= 1'b0;
      fetch_prev_q <= 1'b0;
      last_fetch_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      halt_prev_q  <= cpu_halt;
      wr_prev_q    <= bus_wr;
      fetch_prev_q <= fetch_act;
      if (fetch_cap) last_fetch_q <= bus_addr;
      if (fifo_drop) ovf_q <= 1'b1;
    end
  end

  cpu_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_rec),
    .pop_i       (trace_ready),
    .valid_o     (trace_valid),
    .pop_data_o  (pop_rec),
    .drop_o      (fifo_drop)
  );

  assign bank_sel    = tid_q;
  assign test_halted = halted_q;
  assign test_cycles = cycles_q;
  assign trace_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_test_sequencer.sv
// ============================================================================
// Module : tb_cpu_test_sequencer
// Brief  : Randomised self-checking bench for cpu_test_sequencer with a
//          behavioural reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_test_sequencer;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int NT = 3;
  localparam int TW = 16;
  localparam int RC = 2;
  localparam int DEPTH = 16;
  localparam int WATCH = 2;

  logic clk = 1'b0;
  logic rst, start, trace_ready, cpu_halt, cpu_fetch, bus_rd, bus_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic [NT*TW-1:0] timeout_vec;
  logic cpu_rst_n, trace_valid, trace_kind, test_done, test_halted, busy, all_done, trace_ovf;
  logic [1:0] bank_sel, trace_tid;
  logic [AW-1:0] trace_addr;
  logic [DW-1:0] trace_data;
  logic [TW-1:0] test_cycles;
`ifdef CPU_TEST_TIMESTAMP_EN
  logic [TW-1:0] trace_time;
`endif

  cpu_test_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .timeout_vec(timeout_vec),
    .cpu_rst_n(cpu_rst_n), .bank_sel(bank_sel), .cpu_halt(cpu_halt),
    .cpu_fetch(cpu_fetch), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_data(bus_data), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_kind(trace_kind), .trace_tid(trace_tid),
    .trace_addr(trace_addr), .trace_data(trace_data), .test_done(test_done),
    .test_halted(test_halted), .test_cycles(test_cycles), .busy(busy),
    .all_done(all_done), .trace_ovf(trace_ovf)
`ifdef CPU_TEST_TIMESTAMP_EN
    , .trace_time(trace_time)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic k, input int tid, input int addr, input int data);
    logic [1:0]    t = 2'(tid);
    logic [AW-1:0] a = AW'(addr);
    logic [DW-1:0] d = DW'(data);
    return {k, t, a, d};
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [23:0] rec; int t; } ent_t;
  ent_t m_q[$];
  bit   m_ok = 0;
  int   m_tid, m_cnt, m_rst_left, m_cycles, m_last;
  bit   m_run, m_rep, m_done, m_halted, m_hp, m_wp, m_fp, m_ovf;

  // logs of observed DUT activity, pinned by literal checks
  int          cyc = 0;
  int          gap = 0;
  bit          prev_all = 0;
  int          d_halted[$], d_cycles[$], d_bank[$], d_at[$], ad_at[$], gaps[$];
  logic [23:0] pops[$];

  function automatic int limit_of(input int t);
    int v = int'(timeout_vec[t*TW +: TW]);
    return (v == 0) ? (1 << TW) : v;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (m_ok) begin
      chk("cpu_rst_n", cpu_rst_n, m_run);
      chk("bank_sel", bank_sel, m_tid);
      chk("busy", busy, (m_rst_left > 0) || m_run || m_rep);
      chk("all_done", all_done, m_done);
      chk("test_done", test_done, m_rep);
      chk("trace_valid", trace_valid, m_q.size() != 0);
      chk("trace_ovf", trace_ovf, m_ovf);
      if (m_rep) begin
        chk("test_halted", test_halted, m_halted);
        chk("test_cycles", test_cycles, m_cycles);
      end
      if (m_q.size() != 0) begin
        chk("trace_rec", {trace_kind, trace_tid, trace_addr, trace_data}, m_q[0].rec);
`ifdef CPU_TEST_TIMESTAMP_EN
        chk("trace_time", trace_time, m_q[0].t);
`endif
      end
      if (test_done) begin
        d_halted.push_back(test_halted); d_cycles.push_back(test_cycles);
        d_bank.push_back(bank_sel); d_at.push_back(cyc);
      end
      if (trace_valid && trace_ready) pops.push_back({trace_kind, trace_tid, trace_addr, trace_data});
      if (all_done && !prev_all) ad_at.push_back(cyc);
      prev_all = all_done;
      if (busy && !cpu_rst_n && !test_done) gap++;
      if (cpu_rst_n && gap > 0) begin gaps.push_back(gap); gap = 0; end
    end
    // advance the model across the coming rising edge
    if (rst) begin
      m_ok = 1; m_q.delete();
      m_tid = 0; m_cnt = 0; m_rst_left = 0; m_cycles = 0; m_last = 0;
      m_run = 0; m_rep = 0; m_done = 0; m_halted = 0;
      m_hp = 0; m_wp = 0; m_fp = 0; m_ovf = 0; gap = 0;
    end else if (m_ok) begin
      bit fa, fcap, scap;
      fa   = cpu_fetch && bus_rd;
      fcap = m_run && fa && (!m_fp || int'(bus_addr) != m_last);
      scap = m_run && bus_wr && !m_wp && int'(bus_addr) == WATCH;
      if (fcap) m_last = int'(bus_addr);
      if (trace_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (fcap || scap) begin
        ent_t e;
        e.rec = mk(scap, m_tid, int'(bus_addr), int'(bus_data));
        e.t   = m_cnt;
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else m_ovf = 1;
      end
      if (m_rep) begin
        m_rep = 0;
        if (m_tid == NT - 1) m_done = 1;
        else begin m_tid++; m_rst_left = RC; end
      end else if (m_rst_left > 0) begin
        m_rst_left--;
        if (m_rst_left == 0) begin m_run = 1; m_cnt = 0; end
      end else if (m_run) begin
        bit hr;
        hr = cpu_halt && !m_hp;
        if (hr || (m_cnt + 1 == limit_of(m_tid))) begin
          m_halted = hr;
          m_cycles = (m_cnt + 1 > (1 << TW) - 1) ? (1 << TW) - 1 : m_cnt + 1;
          m_run = 0; m_rep = 1;
        end else m_cnt++;
      end else if (start) begin
        m_done = 0; m_tid = 0; m_rst_left = RC;
      end
      m_hp = cpu_halt; m_wp = bus_wr; m_fp = fa;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    cpu_halt = 0; cpu_fetch = 0; bus_rd = 0; bus_wr = 0; bus_addr = '0; bus_data = '0;
  endtask

  task automatic wait_run(input string nm, input int budget);
    int n = 0;
    while (cpu_rst_n !== 1'b1 && n < budget) begin step(); n++; end
    if (cpu_rst_n !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s: cpu_rst_n still 0x%0h after %0d cycles, required 0x1", nm, cpu_rst_n, budget);
    end
  endtask

  // Random bus traffic until all_done; halt only raised while bank 2 is selected
  task automatic run_noise(input string nm, input bit halt_en, input int budget);
    int n = 0;
    while (all_done !== 1'b1 && n < budget) begin
      cpu_fetch   = ($urandom % 2) == 0;
      bus_rd      = ($urandom % 4) != 0;
      bus_wr      = ($urandom % 3) == 0;
      bus_addr    = AW'($urandom % 6);
      bus_data    = DW'($urandom);
      trace_ready = ($urandom % 2) == 0;
      cpu_halt    = halt_en && bank_sel == 2'd2 && ($urandom % 40) == 0;
      step(); n++;
    end
    idle_bus(); trace_ready = 1;
    if (all_done !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s: all_done 0x%0h after %0d cycles, required 0x1", nm, all_done, budget);
    end
  endtask

  initial begin
    int base;
    idle_bus(); rst = 1; start = 0; trace_ready = 1;
    timeout_vec = {16'd940, 16'd113, 16'd148};
    repeat (3) step();
    rst = 0; step();
    chk("reset_cycles", test_cycles, 0);
    chk("reset_rst_n", cpu_rst_n, 0);

    // Run A: test 0 directed with halt at cycle 100, then random traffic
    start = 1; step(); start = 0;
    wait_run("run_a0", 10);
    for (int c = 1; c <= 100; c++) begin
      idle_bus();
      case (c)
        2:  begin cpu_fetch = 1; bus_rd = 1; bus_addr = 13'h000; bus_data = 8'hA0; end
        4:  begin cpu_fetch = 1; bus_rd = 1; bus_addr = 13'h002; bus_data = 8'hC0; end
        6:  begin cpu_fetch = 1; bus_rd = 1; bus_addr = 13'h004; bus_data = 8'hE0; end
        10: begin bus_wr = 1; bus_addr = 13'h002; bus_data = 8'h01; end
        12: begin bus_wr = 1; bus_addr = 13'h002; bus_data = 8'h02; end
        14: begin bus_wr = 1; bus_addr = 13'h002; bus_data = 8'h03; end
        16: begin bus_wr = 1; bus_addr = 13'h003; bus_data = 8'h55; end
        100: cpu_halt = 1;
        default: ;
      endcase
      step();
    end
    idle_bus();
    run_noise("run_a", 1, 3000);
    step();
    chk("a_done_count", d_halted.size(), 3);
    chk("a_t0_halted", d_halted[0], 1);
    chk("a_t0_cycles", d_cycles[0], 100);
    chk("a_t0_bank", d_bank[0], 0);
    chk("a_t1_halted", d_halted[1], 0);
    chk("a_t1_cycles", d_cycles[1], 113);
    chk("a_t1_bank", d_bank[1], 1);
    chk("a_t2_bank", d_bank[2], 2);
    chk("a_all_done_lag", ad_at[0] - d_at[2], 1);
    chk("a_pop_count_min", pops.size() >= 6, 1);
    chk("a_rec0", pops[0], mk(0, 0, 13'h000, 8'hA0));
    chk("a_rec1", pops[1], mk(0, 0, 13'h002, 8'hC0));
    chk("a_rec2", pops[2], mk(0, 0, 13'h004, 8'hE0));
    chk("a_rec3", pops[3], mk(1, 0, 13'h002, 8'h01));
    chk("a_rec4", pops[4], mk(1, 0, 13'h002, 8'h02));
    chk("a_rec5", pops[5], mk(1, 0, 13'h002, 8'h03));

    // Run B: every test times out at 20 cycles
    timeout_vec = {16'd20, 16'd20, 16'd20};
    start = 1; step(); start = 0;
    run_noise("run_b", 0, 300);
    step();
    chk("b_done_count", d_halted.size(), 6);
    for (int i = 3; i < 6; i++) begin
      chk("b_cycles", d_cycles[i], 20);
      chk("b_halted", d_halted[i], 0);
    end
    chk("gap_count", gaps.size(), 6);
    foreach (gaps[i]) chk("reset_gap", gaps[i], RC);

    // Run C: overflow, drain order, store/fetch collision, mid-run reset
    rst = 1; step(); step(); rst = 0; step();
    timeout_vec = {16'd0, 16'd1000, 16'd1000};
    start = 1; step(); start = 0;
    wait_run("run_c0", 10);
    trace_ready = 0;
    for (int i = 0; i < 20; i++) begin
      cpu_fetch = 1; bus_rd = 1; bus_addr = AW'(13'h100 + 2 * i); bus_data = DW'(i);
      step();
    end
    idle_bus(); step();
    chk("c_ovf_set", trace_ovf, 1);
    base = pops.size();
    trace_ready = 1;
    repeat (20) step();
    chk("c_drained", trace_valid, 0);
    chk("c_ovf_sticky", trace_ovf, 1);
    chk("c_drain_count", pops.size() - base, 16);
    for (int i = 0; i < 16; i++) chk("c_drain_rec", pops[base + i], mk(0, 0, 13'h100 + 2 * i, i));
    trace_ready = 0;
    cpu_fetch = 1; bus_rd = 1; bus_wr = 1; bus_addr = 13'h002; bus_data = 8'h77;
    step(); idle_bus(); step();
    chk("c_collide_rec", {trace_valid, trace_kind, trace_addr, trace_data}, {1'b1, 1'b1, 13'h002, 8'h77});
    trace_ready = 1; step();
    chk("c_collide_single", trace_valid, 0);
    cpu_halt = 1; step(); idle_bus();
    wait_run("run_c1", 10);
    repeat (5) step();
    base = d_halted.size();
    rst = 1; step(); rst = 0;
    chk("c_rst_rst_n", cpu_rst_n, 0);
    chk("c_rst_busy", busy, 0);
    chk("c_rst_ovf", trace_ovf, 0);
    chk("c_rst_bank", bank_sel, 0);
    chk("c_rst_done", test_done, 0);
    repeat (5) step();
    chk("c_no_done", d_halted.size() - base, 0);
    start = 1; step(); start = 0;
    chk("c_restart_bank", bank_sel, 0);
    chk("c_restart_busy", busy, 1);
    repeat (4) step();
    rst = 1; step(); rst = 0; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
